imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Sequences the byte-addressed, word-read instruction memory.
- Owns the byte-write port during a boot LOAD phase, then runs the PC and the IF/ID pipeline register in RUN.
- Arbitrates memory ownership between the serial program loader and instruction fetch, and applies stall and branch-flush from the hazard and branch logic.
- Sits between the instruction memory and the ID stage.

Parameters:
N, 400, instruction memory size in bytes
PC_W, 32, PC and address width
RESET_PC, 0, PC value on entry to RUN (word aligned)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  loader byte strobe
load_byte  in  8  loader byte data
load_done  in  1  loader finished, one-cycle pulse
mem_we  out  1  memory byte write enable
mem_waddr  out  PC_W  memory byte write address
mem_wdata  out  8  memory byte write data
mem_addr  out  PC_W  fetch address to memory
mem_rdata  in  32  combinational instruction word from memory
stall  in  1  hold PC and IF/ID
branch_taken  in  1  redirect and flush
branch_target  in  PC_W  redirect address
ifid_inst  out  32  IF/ID instruction
ifid_pc4  out  PC_W  IF/ID PC+4
ifid_valid  out  1  IF/ID holds a real instruction
fetch_oob  out  1  current PC outside [0, N-4]
load_ovf  out  1  sticky: loader byte arrived with load_ptr at N
running  out  1  state == RUN

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD, load_ptr=0, pc=RESET_PC.
  - ifid_inst=0, ifid_pc4=0, ifid_valid=0, load_ovf=0, running=0.
  - mem_we=0 combinationally.
  - Reset mid-LOAD or mid-RUN aborts everything; memory contents are not cleared.
- States: LOAD -> RUN on load_done. RUN has no exit except reset.
- LOAD:
  - mem_we = load_valid && (load_ptr < N); mem_waddr=load_ptr; mem_wdata=load_byte (combinational).
  - On a clock edge with load_valid: if load_ptr<N, load_ptr++; else set load_ovf and drop the byte.
  - mem_addr=0, ifid_valid stays 0, stall and branch are ignored.
- load_valid and load_done in the same cycle: the byte is written first, then state=RUN on that edge.
- On the LOAD->RUN edge: pc=RESET_PC, IF/ID stays cleared. The first valid IF/ID appears one cycle later (fetch latency 1 cycle).
- RUN:
  - mem_we=0, mem_addr=pc.
  - load_valid and load_done are ignored, and load_ovf holds its value.
- RUN per-edge priority:
  1. branch_taken: pc = {branch_target[PC_W-1:2], 2'b00}; ifid_inst=0, ifid_valid=0, ifid_pc4 held (flush; beats stall).
  2. stall: pc, ifid_inst, ifid_pc4, ifid_valid all held.
  3. else: ifid_inst=mem_rdata, ifid_pc4=pc+4, ifid_valid=1, pc=pc+4.
- Arithmetic: pc+4 is computed in PC_W bits and wraps modulo 2^PC_W. No overflow flag.
- fetch_oob = running && (pc > N-4), combinational. An out-of-range fetch still advances and latches the memory's zero word (nop) with ifid_valid=1. Flagging only, no trap.
- Branch to the current pc is legal and behaves as a flush.
- RUN while rst_n is high and no reset occurs is permanent. A second load requires a reset.

Test Plan:
1. Reset, load 8 bytes 0x00..0x07 with load_valid each cycle, then load_done -> mem_waddr 0..7 with mem_we high. running=1 the next cycle. First edge in RUN gives ifid_pc4=4, ifid_valid=1, ifid_inst=mem_rdata at address 0.
2. RUN from pc=0, no stall, 3 cycles, then stall for 2 cycles -> pc goes 4, 8, 12, then holds at 12. ifid_pc4 holds at 12 and ifid_inst is unchanged during the stall.
3. At pc=8 assert branch_taken and stall together with branch_target=0x22 -> pc=0x20, ifid_valid=0, ifid_inst=0. The next free cycle gives ifid_pc4=0x24, ifid_valid=1.
4. N=400: load 401 bytes -> bytes 0..399 written, the 401st byte gives mem_we=0 and load_ovf=1. Branch to 396 -> fetch_oob=0; next pc=400 -> fetch_oob=1 and the next ifid_inst=0.
5. Drop rst_n mid-RUN at pc=0x40 with ifid_valid=1 -> outputs clear immediately, before the next clock edge: state=LOAD, pc=RESET_PC, ifid_valid=0. load_ptr restarts at 0.
6. load_valid and load_done asserted in the same cycle at load_ptr=5 -> byte written to address 5, then running=1 on that edge. A later load_valid in RUN gives mem_we=0.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, the loader, the instruction memory
// and the ID-side hazard/branch logic.
interface imem_fetch_ctrl_if #(
  parameter int PC_W = 32
);
  logic            load_valid;
  logic [7:0]      load_byte;
  logic            load_done;
  logic            mem_we;
  logic [PC_W-1:0] mem_waddr;
  logic [7:0]      mem_wdata;
  logic [PC_W-1:0] mem_addr;
  logic [31:0]     mem_rdata;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [31:0]     ifid_inst;
  logic [PC_W-1:0] ifid_pc4;
  logic            ifid_valid;
  logic            fetch_oob;
  logic            load_ovf;
  logic            running;

  modport master (
    input  load_valid, load_byte, load_done, mem_rdata,
           stall, branch_taken, branch_target,
    output mem_we, mem_waddr, mem_wdata, mem_addr,
           ifid_inst, ifid_pc4, ifid_valid, fetch_oob, load_ovf, running
  );

  modport slave (
    output load_valid, load_byte, load_done, mem_rdata,
           stall, branch_taken, branch_target,
    input  mem_we, mem_waddr, mem_wdata, mem_addr,
           ifid_inst, ifid_pc4, ifid_valid, fetch_oob, load_ovf, running
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: boot-time byte loader (LOAD), then PC and
// IF/ID register with stall and branch-flush (RUN).
module imem_fetch_ctrl #(
  parameter int N        = 400,
  parameter int PC_W     = 32,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_fetch_ctrl_if.master   bus
);

  localparam logic [PC_W-1:0] N_L        = PC_W'(N);
  localparam logic [PC_W-1:0] LAST_WORD  = PC_W'(N - 4);
  localparam logic [PC_W-1:0] RESET_PC_L = PC_W'(RESET_PC);

  typedef enum logic {S_LOAD, S_RUN} state_e;

  state_e          state_q;
  logic [PC_W-1:0] load_ptr_q, load_ptr_d;
  logic [PC_W-1:0] pc_q, pc4_d, br_pc_d;
  logic [31:0]     ifid_inst_q;
  logic [PC_W-1:0] ifid_pc4_q;
  logic            ifid_valid_q;
  logic            load_ovf_q;
  logic            ptr_ok;
  logic            run;

  assign run        = (state_q == S_RUN);
  assign ptr_ok     = (load_ptr_q < N_L);
  assign load_ptr_d = load_ptr_q + PC_W'(1);
  assign pc4_d      = pc_q + PC_W'(4);
  assign br_pc_d    = {bus.branch_target[PC_W-1:2], 2'b00};

  // Write port is gated by rst_n so it is quiet while reset is held.
  assign bus.mem_we     = rst_n && !run && bus.load_valid && ptr_ok;
  assign bus.mem_waddr  = load_ptr_q;
  assign bus.mem_wdata  = bus.load_byte;
  assign bus.mem_addr   = run ? pc_q : '0;
  assign bus.ifid_inst  = ifid_inst_q;
  assign bus.ifid_pc4   = ifid_pc4_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.load_ovf   = load_ovf_q;
  assign bus.running    = run;
  assign bus.fetch_oob  = run && (pc_q > LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      load_ptr_q   <= '0;
      pc_q         <= RESET_PC_L;
      ifid_inst_q  <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      load_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          // A byte arriving with load_done is still written before switching.
          if (bus.load_valid) begin
            if (ptr_ok) load_ptr_q <= load_ptr_d;
            else        load_ovf_q <= 1'b1;
          end
          if (bus.load_done) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC_L;
          end
        end
        S_RUN: begin
          // Flush wins over stall; the flushed slot keeps its old pc4.
          if (bus.branch_taken) begin
            pc_q         <= br_pc_d;
            ifid_inst_q  <= '0;
            ifid_valid_q <= 1'b0;
          end else if (!bus.stall) begin
            pc_q         <= pc4_d;
            ifid_inst_q  <= bus.mem_rdata;
            ifid_pc4_q   <= pc4_d;
            ifid_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: vector table for load/run/stall/branch,
// plus hand sequences for overflow, out-of-range fetch, async reset, load_done overlap.
module tb_imem_fetch_ctrl;
  localparam int N = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(.PC_W(32)) bus ();

  imem_fetch_ctrl #(.N(N), .PC_W(32), .RESET_PC(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Byte memory model with a combinational little-endian word read.
  logic [7:0] mem [0:N-1] = '{default: 8'h00};
  int wr_cnt = 0;

  always @(posedge clk)
    if (bus.mem_we) begin
      if (bus.mem_waddr < N) mem[bus.mem_waddr] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (a <= 32'(N - 4)) return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    return 32'h0;
  endfunction

  always_comb bus.mem_rdata = rd_word(bus.mem_addr);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        lv;
    logic [7:0]  lb;
    logic        ld;
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        e_we;
    logic [31:0] e_waddr;
    logic        e_run;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc4;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(input logic lv, input logic [7:0] lb, input logic ld,
                              input logic st, input logic br, input logic [31:0] tgt,
                              input logic e_we, input logic [31:0] e_waddr,
                              input logic e_run, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_pc4,
                              input logic [31:0] e_inst);
    vec_t v;
    v = '{lv, lb, ld, st, br, tgt, e_we, e_waddr, e_run, e_addr, e_vld, e_pc4, e_inst};
    return v;
  endfunction

  task automatic drive(input logic lv, input logic [7:0] lb, input logic ld,
                       input logic st, input logic br, input logic [31:0] tgt);
    bus.load_valid    = lv;
    bus.load_byte     = lb;
    bus.load_done     = ld;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    int c0;
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 32'h0);
    #3;
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_running", 32'(bus.running), 32'h0);
    chk("rst_ifid_valid", 32'(bus.ifid_valid), 32'h0);
    chk("rst_ifid_inst", bus.ifid_inst, 32'h0);
    chk("rst_ifid_pc4", bus.ifid_pc4, 32'h0);
    chk("rst_load_ovf", 32'(bus.load_ovf), 32'h0);
    chk("rst_fetch_oob", 32'(bus.fetch_oob), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    edge1();

    // Load 0x00..0x07; stall/branch during LOAD are ignored.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 8'(i), 1'b0, i == 7, i == 7, 32'h80,
                        1'b1, 32'(i), 1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(0,0,1, 0,0,0,        0,0, 1,32'h00, 0,32'h00, 32'h0));
    vecs.push_back(mk(0,0,0, 0,0,0,        0,0, 1,32'h04, 1,32'h04, 32'h03020100));
    vecs.push_back(mk(0,0,0, 0,0,0,        0,0, 1,32'h08, 1,32'h08, 32'h07060504));
    vecs.push_back(mk(0,0,0, 0,0,0,        0,0, 1,32'h0C, 1,32'h0C, 32'h0));
    vecs.push_back(mk(0,0,0, 1,0,0,        0,0, 1,32'h0C, 1,32'h0C, 32'h0));
    vecs.push_back(mk(0,0,0, 1,0,0,        0,0, 1,32'h0C, 1,32'h0C, 32'h0));
    vecs.push_back(mk(0,0,0, 0,1,32'h08,   0,0, 1,32'h08, 0,32'h0C, 32'h0));
    vecs.push_back(mk(0,0,0, 1,1,32'h22,   0,0, 1,32'h20, 0,32'h0C, 32'h0));
    vecs.push_back(mk(0,0,0, 0,0,0,        0,0, 1,32'h24, 1,32'h24, 32'h0));
    vecs.push_back(mk(0,0,0, 0,1,32'h03,   0,0, 1,32'h00, 0,32'h24, 32'h0));
    vecs.push_back(mk(0,0,0, 0,0,0,        0,0, 1,32'h04, 1,32'h04, 32'h03020100));
    vecs.push_back(mk(0,0,0, 1,0,0,        0,0, 1,32'h04, 1,32'h04, 32'h03020100));
    vecs.push_back(mk(1,8'hEE,1, 0,0,0,    0,0, 1,32'h08, 1,32'h08, 32'h07060504));
    vecs.push_back(mk(0,0,0, 0,1,32'h08,   0,0, 1,32'h08, 0,32'h08, 32'h0));

    foreach (vecs[k]) begin
      drive(vecs[k].lv, vecs[k].lb, vecs[k].ld, vecs[k].st, vecs[k].br, vecs[k].tgt);
      #2;
      chk($sformatf("v%0d_mem_we", k), 32'(bus.mem_we), 32'(vecs[k].e_we));
      if (vecs[k].e_we) chk($sformatf("v%0d_waddr", k), bus.mem_waddr, vecs[k].e_waddr);
      edge1();
      chk($sformatf("v%0d_running", k), 32'(bus.running), 32'(vecs[k].e_run));
      chk($sformatf("v%0d_mem_addr", k), bus.mem_addr, vecs[k].e_addr);
      chk($sformatf("v%0d_ifid_valid", k), 32'(bus.ifid_valid), 32'(vecs[k].e_vld));
      chk($sformatf("v%0d_ifid_pc4", k), bus.ifid_pc4, vecs[k].e_pc4);
      chk($sformatf("v%0d_ifid_inst", k), bus.ifid_inst, vecs[k].e_inst);
    end

    // Overflow: 401 bytes, last one dropped.
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    c0 = wr_cnt;
    for (int i = 0; i <= N; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      if (i == N) chk("ovf_we_dropped", 32'(bus.mem_we), 32'h0);
      else if (i == 0 || i == N - 1) begin
        chk("ovf_we", 32'(bus.mem_we), 32'h1);
        chk("ovf_waddr", bus.mem_waddr, 32'(i));
      end
      if (i == N - 1) chk("ovf_not_yet", 32'(bus.load_ovf), 32'h0);
      edge1();
    end
    chk("ovf_sticky", 32'(bus.load_ovf), 32'h1);
    chk("ovf_wr_count", 32'(wr_cnt - c0), 32'(N));
    drive(0, 0, 1, 0, 0, 0);
    edge1();
    chk("ovf_running", 32'(bus.running), 32'h1);
    drive(0, 0, 0, 0, 1, 32'd396);
    edge1();
    chk("oob_396_addr", bus.mem_addr, 32'd396);
    chk("oob_396_flag", 32'(bus.fetch_oob), 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    edge1();
    chk("oob_400_addr", bus.mem_addr, 32'd400);
    chk("oob_400_flag", 32'(bus.fetch_oob), 32'h1);
    chk("oob_last_word", bus.ifid_inst, 32'h8F8E8D8C);
    drive(1, 8'h11, 0, 0, 0, 0);
    #2;
    chk("run_lv_we", 32'(bus.mem_we), 32'h0);
    edge1();
    chk("oob_nop_inst", bus.ifid_inst, 32'h0);
    chk("oob_nop_valid", 32'(bus.ifid_valid), 32'h1);
    chk("oob_nop_pc4", bus.ifid_pc4, 32'd404);
    chk("run_ovf_held", 32'(bus.load_ovf), 32'h1);
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    edge1();
    chk("wrap_pc", bus.mem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0, 0);
    edge1();
    chk("wrap_addr", bus.mem_addr, 32'h0);
    chk("wrap_pc4", bus.ifid_pc4, 32'h0);
    chk("wrap_oob", 32'(bus.fetch_oob), 32'h0);

    // Async reset mid-RUN at pc=0x40 with a valid IF/ID.
    drive(0, 0, 0, 0, 1, 32'h3C);
    edge1();
    drive(0, 0, 0, 0, 0, 0);
    edge1();
    chk("pre_rst_addr", bus.mem_addr, 32'h40);
    chk("pre_rst_valid", 32'(bus.ifid_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_running", 32'(bus.running), 32'h0);
    chk("arst_addr", bus.mem_addr, 32'h0);
    chk("arst_valid", 32'(bus.ifid_valid), 32'h0);
    chk("arst_pc4", bus.ifid_pc4, 32'h0);
    chk("arst_ovf", 32'(bus.load_ovf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    edge1();

    // Reload 5 bytes, then byte 5 together with load_done.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      if (i == 0) chk("reload_waddr0", bus.mem_waddr, 32'h0);
      edge1();
    end
    drive(1, 8'hA5, 1, 0, 0, 0);
    #2;
    chk("both_we", 32'(bus.mem_we), 32'h1);
    chk("both_waddr", bus.mem_waddr, 32'h5);
    edge1();
    chk("both_running", 32'(bus.running), 32'h1);
    chk("both_valid", 32'(bus.ifid_valid), 32'h0);
    drive(1, 8'h33, 0, 0, 0, 0);
    #2;
    chk("both_run_we", 32'(bus.mem_we), 32'h0);
    edge1();
    chk("both_w0", bus.ifid_inst, 32'hA3A2A1A0);
    drive(0, 0, 0, 0, 0, 0);
    edge1();
    chk("both_w1", bus.ifid_inst, 32'h0706A5A4);
    chk("both_pc4", bus.ifid_pc4, 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
